// File: rtl/tdm_demux_8.sv
// tdm_demux_8: time-multiplexed serial stream to 8 parallel channels, frame-sync locked, double-buffered.
// Define TDM_DEMUX_PARITY_EN for a 9-slot frame whose last slot carries even parity over slots 0..7.
module tdm_demux_8 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7,
    output logic [2:0]       slot,
    output logic             locked,
    output logic             frame_done,
    output logic             sync_err,
    output logic             parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_W = 4;
    localparam int NSH    = 8;
`else
    localparam int SLOT_W = 3;
    localparam int NSH    = 7;
`endif
    // The final slot index equals the number of shadowed slots.
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSH);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t            r_state, w_state_next;
    logic [SLOT_W-1:0] r_slot, w_slot_next;
    logic [WIDTH-1:0]  r_shadow [0:NSH-1];
    logic [WIDTH-1:0]  r_y      [0:7];
    logic              r_frame_done, w_done_next;
    logic              r_sync_err, w_serr_next;
    logic              w_shadow_we;
    logic [2:0]        w_wr_idx;
    logic              w_load_y;
    logic              w_perr_next;

`ifdef TDM_DEMUX_PARITY_EN
    logic r_parity_err;
    logic w_par;

    // Even parity: the XOR of every data bit plus the parity bit must be 0.
    always_comb begin
        w_par = din[0];
        for (int i = 0; i < NSH; i++) begin
            w_par = w_par ^ (^r_shadow[i]);
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_slot_next  = r_slot;
        w_shadow_we  = 1'b0;
        w_wr_idx     = r_slot[2:0];
        w_load_y     = 1'b0;
        w_done_next  = 1'b0;
        w_serr_next  = 1'b0;
        w_perr_next  = 1'b0;
        if (en) begin
            case (r_state)
                HUNT: begin
                    if (sync) begin
                        w_shadow_we  = 1'b1;
                        w_wr_idx     = 3'd0;
                        w_slot_next  = SLOT_W'(1);
                        w_state_next = LOCKED;
                    end
                end
                default: begin
                    if (sync) begin
                        // An early sync restarts the frame from this sample.
                        w_serr_next = (r_slot != '0);
                        w_shadow_we = 1'b1;
                        w_wr_idx    = 3'd0;
                        w_slot_next = SLOT_W'(1);
                    end else if (r_slot == '0) begin
                        w_serr_next  = 1'b1;
                        w_slot_next  = '0;
                        w_state_next = HUNT;
                    end else if (r_slot == LAST_SLOT) begin
                        w_slot_next = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        if (!w_par) begin
                            w_load_y    = 1'b1;
                            w_done_next = 1'b1;
                        end else begin
                            w_perr_next = 1'b1;
                        end
`else
                        w_load_y    = 1'b1;
                        w_done_next = 1'b1;
`endif
                    end else begin
                        w_shadow_we = 1'b1;
                        w_slot_next = r_slot + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HUNT;
            r_slot       <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_slot       <= w_slot_next;
            r_frame_done <= w_done_next;
            r_sync_err   <= w_serr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSH; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shadow[gi] <= '0;
                end else if (w_shadow_we && (w_wr_idx == 3'(gi))) begin
                    r_shadow[gi] <= din;
                end
            end
        end

        // Without parity the last channel is taken straight from the final sample.
        for (gi = 0; gi < 8; gi++) begin : g_out
            if (gi < NSH) begin : g_from_shadow
                always_ff @(posedge clk) begin
                    if (rst)           r_y[gi] <= '0;
                    else if (w_load_y) r_y[gi] <= r_shadow[gi];
                end
            end else begin : g_from_din
                always_ff @(posedge clk) begin
                    if (rst)           r_y[gi] <= '0;
                    else if (w_load_y) r_y[gi] <= din;
                end
            end
        end
    endgenerate

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) r_parity_err <= 1'b0;
        else     r_parity_err <= w_perr_next;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = w_perr_next & 1'b0;
`endif

    assign y0         = r_y[0];
    assign y1         = r_y[1];
    assign y2         = r_y[2];
    assign y3         = r_y[3];
    assign y4         = r_y[4];
    assign y5         = r_y[5];
    assign y6         = r_y[6];
    assign y7         = r_y[7];
    assign slot       = r_slot[2:0];
    assign locked     = (r_state == LOCKED);
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

endmodule
